md5_compress_core: RTL and testbench

//  Iterative MD5 compression engine: processes one 512-bit message block

---
 rtl/md5_pkg.sv | 60 ++++++
 rtl/md5_step.sv | 32 +++
 rtl/md5_compress_core.sv | 146 ++++++++++++++
 tb/tb_md5_compress_core.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md5_pkg.sv
// Shared MD5 tables, types and round helpers for the compression core.
package md5_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {IDLE, RUN, FINAL, DONE} state_e;

    localparam word_t K_TAB [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };

    localparam logic [4:0] S_TAB [64] = '{
        5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22,
        5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22,
        5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20,
        5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20,
        5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23,
        5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23,
        5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21,
        5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21
    };

    function automatic word_t md5_f(input logic [1:0] r, input word_t b, input word_t c,
                                    input word_t d);
        case (r)
            2'd0:    md5_f = (b & c) | (~b & d);
            2'd1:    md5_f = (b & d) | (c & ~d);
            2'd2:    md5_f = b ^ c ^ d;
            default: md5_f = c ^ (b | ~d);
        endcase
    endfunction

    // Message word index; arithmetic in 4 bits gives the mod-16 for free.
    function automatic logic [3:0] md5_g(input logic [5:0] i);
        logic [3:0] j;
        j = i[3:0];
        case (i[5:4])
            2'd0:    md5_g = j;
            2'd1:    md5_g = j * 4'd5 + 4'd1;
            2'd2:    md5_g = j * 4'd3 + 4'd5;
            default: md5_g = j * 4'd7;
        endcase
    endfunction

endpackage

// File: rtl/md5_step.sv
// One combinational MD5 step; chained STEPS_PER_CYCLE deep by the core.
module md5_step
    import md5_pkg::*;
(
    input  logic [1:0] r_in,
    input  logic [4:0] s_in,
    input  word_t      a_in,
    input  word_t      b_in,
    input  word_t      c_in,
    input  word_t      d_in,
    input  word_t      m_in,
    input  word_t      k_in,
    output word_t      a_out,
    output word_t      b_out,
    output word_t      c_out,
    output word_t      d_out
);

    word_t       tmp;
    logic [63:0] rot;

    always_comb begin
        tmp = a_in + md5_f(r_in, b_in, c_in, d_in) + m_in + k_in;
        rot = {tmp, tmp} << s_in;
    end

    assign a_out = d_in;
    assign b_out = b_in + rot[63:32];
    assign c_out = b_in;
    assign d_out = c_in;

endmodule

// File: rtl/md5_compress_core.sv
// Iterative MD5 compression: 64 steps at STEPS_PER_CYCLE per clock, then
// feed-forward add and an optional registered digest stage.
module md5_compress_core
    import md5_pkg::*;
#(
    parameter int STEPS_PER_CYCLE = 1,
    parameter bit OUT_REG         = 1'b1
) (
    input  logic         PCLK_IN,
    input  logic         PRESETN_IN,
    input  logic         blk_valid_in,
    output logic         blk_ready_out,
    input  logic [511:0] blk_data_in,
    input  logic [127:0] chain_in,
    output logic         dig_valid_out,
    input  logic         dig_ready_in,
    output logic [127:0] dig_out,
    output logic         busy_out
);

    localparam int SPC = STEPS_PER_CYCLE;

    state_e       state_q, state_d;
    logic [5:0]   i_q, i_d;
    logic [511:0] blk_q, blk_d;
    logic [127:0] chain_q, chain_d;
    word_t        a_q, b_q, c_q, d_q, a_d, b_d, c_d, d_d;
    logic [127:0] dig_q, dig_d;
    logic         dv_q, dv_d, ready_q, ready_d, busy_q, busy_d;

    logic [SPC:0][31:0] ca, cb, cc, cd;

    assign ca[0] = a_q;
    assign cb[0] = b_q;
    assign cc[0] = c_q;
    assign cd[0] = d_q;

    for (genvar k = 0; k < SPC; k++) begin : g_step
        logic [5:0] idx;
        word_t      m;
        assign idx = i_q + 6'(k);
        assign m   = blk_q[{md5_g(idx), 5'd0} +: 32];

        md5_step u_step (
            .r_in  (idx[5:4]),
            .s_in  (S_TAB[idx]),
            .a_in  (ca[k]),
            .b_in  (cb[k]),
            .c_in  (cc[k]),
            .d_in  (cd[k]),
            .m_in  (m),
            .k_in  (K_TAB[idx]),
            .a_out (ca[k+1]),
            .b_out (cb[k+1]),
            .c_out (cc[k+1]),
            .d_out (cd[k+1])
        );
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        blk_d   = blk_q;
        chain_d = chain_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        d_d     = d_q;
        dig_d   = dig_q;
        dv_d    = dv_q;
        case (state_q)
            IDLE: if (blk_valid_in) begin
                blk_d                = blk_data_in;
                chain_d              = chain_in;
                {d_d, c_d, b_d, a_d} = chain_in;
                i_d                  = '0;
                state_d              = RUN;
            end
            RUN: begin
                a_d = ca[SPC];
                b_d = cb[SPC];
                c_d = cc[SPC];
                d_d = cd[SPC];
                i_d = i_q + 6'(SPC);
                if (i_q == 6'(64 - SPC)) state_d = FINAL;
            end
            FINAL: begin
                a_d     = a_q + chain_q[31:0];
                b_d     = b_q + chain_q[63:32];
                c_d     = c_q + chain_q[95:64];
                d_d     = d_q + chain_q[127:96];
                state_d = DONE;
            end
            default: if (dig_valid_out && dig_ready_in) state_d = IDLE;
        endcase
        // Registered output spends one DONE cycle loading dig_q before valid rises.
        if (OUT_REG) begin
            if (state_q == DONE && !dv_q) begin
                dv_d  = 1'b1;
                dig_d = {d_q, c_q, b_q, a_q};
            end else if (dv_q && dig_ready_in) begin
                dv_d = 1'b0;
            end
        end else begin
            dv_d = (state_d == DONE);
        end
        ready_d = (state_d == IDLE);
        busy_d  = (state_d == RUN) || (state_d == FINAL);
    end

    always_ff @(posedge PCLK_IN or negedge PRESETN_IN) begin
        if (!PRESETN_IN) begin
            state_q <= IDLE;
            i_q     <= '0;
            blk_q   <= '0;
            chain_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            dig_q   <= '0;
            dv_q    <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            blk_q   <= blk_d;
            chain_q <= chain_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            d_q     <= d_d;
            dig_q   <= dig_d;
            dv_q    <= dv_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign blk_ready_out = ready_q;
    assign dig_valid_out = dv_q;
    assign busy_out      = busy_q;
    assign dig_out       = OUT_REG ? dig_q : {d_q, c_q, b_q, a_q};

endmodule

// File: tb/tb_md5_compress_core.sv
// Scoreboard bench: four core configurations driven with known vectors and
// random blocks, each checked against a plain-arithmetic MD5 model.
module tb_md5_compress_core;

    localparam int NI = 4;

    function automatic int spc_of(input int k);
        case (k)
            0:       return 4;
            1:       return 1;
            2:       return 16;
            default: return 8;
        endcase
    endfunction

    function automatic bit or_of(input int k);
        return (k != 3);
    endfunction

    localparam logic [127:0] IV        = {32'h10325476, 32'h98badcfe, 32'hefcdab89, 32'h67452301};
    localparam logic [127:0] DIG_EMPTY = {32'h7e42f8ec, 32'h980980e9, 32'h04b2008f, 32'hd98c1dd4};
    localparam logic [127:0] DIG_ABC   = {32'h727fe128, 32'h7d3f96d6, 32'hb04fd23c, 32'h98500190};
    localparam int SH [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [511:0]          blk_data = '0;
    logic [127:0]          chain = '0;
    logic [NI-1:0]         vin = '0;
    logic [NI-1:0]         drdy = '0;
    logic [NI-1:0]         rdy, dv, busy;
    logic [NI-1:0][127:0]  dig;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [31:0] kt [64];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: constants derived from |sin(i+1)|, steps written straight from the algorithm.
    function automatic void init_k();
        real s;
        for (int i = 0; i < 64; i++) begin
            s = $sin(real'(i + 1));
            if (s < 0.0) s = -s;
            kt[i] = 32'(longint'($floor(s * 4294967296.0)));
        end
    endfunction

    function automatic logic [127:0] md5_ref(input logic [127:0] ch, input logic [511:0] blk);
        logic [31:0] a, b, c, d, f, t;
        int r, g, s;
        a = ch[31:0];
        b = ch[63:32];
        c = ch[95:64];
        d = ch[127:96];
        for (int i = 0; i < 64; i++) begin
            r = i / 16;
            case (r)
                0:       begin f = (b & c) | (~b & d); g = i;                end
                1:       begin f = (b & d) | (c & ~d); g = (5 * i + 1) % 16; end
                2:       begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
                default: begin f = c ^ (b | ~d);       g = (7 * i) % 16;     end
            endcase
            t = a + f + blk[g*32 +: 32] + kt[i];
            s = SH[r*4 + i%4];
            t = (t << s) | (t >> (32 - s));
            a = d;
            d = c;
            c = b;
            b = b + t;
        end
        return {d + ch[127:96], c + ch[95:64], b + ch[63:32], a + ch[31:0]};
    endfunction

    function automatic logic [511:0] rand_blk();
        logic [511:0] b;
        for (int w = 0; w < 16; w++) b[w*32 +: 32] = $urandom;
        return b;
    endfunction

    function automatic logic [127:0] rand_ch();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    for (genvar k = 0; k < NI; k++) begin : g_dut
        localparam int LAT = 64 / spc_of(k) + (or_of(k) ? 2 : 1);

        md5_compress_core #(
            .STEPS_PER_CYCLE (spc_of(k)),
            .OUT_REG         (or_of(k))
        ) u_dut (
            .PCLK_IN       (clk),
            .PRESETN_IN    (rst_n),
            .blk_valid_in  (vin[k]),
            .blk_ready_out (rdy[k]),
            .blk_data_in   (blk_data),
            .chain_in      (chain),
            .dig_valid_out (dv[k]),
            .dig_ready_in  (drdy[k]),
            .dig_out       (dig[k]),
            .busy_out      (busy[k])
        );

        logic [127:0] exp_q [$];
        int           acc_q [$];
        bit           seen = 1'b0;

        // Push at acceptance, compare every cycle the digest is presented.
        always @(negedge clk) begin
            if (!rst_n) begin
                exp_q.delete();
                acc_q.delete();
                seen = 1'b0;
            end else begin
                if (vin[k] && rdy[k]) begin
                    exp_q.push_back(md5_ref(chain, blk_data));
                    acc_q.push_back(cyc + 1);
                end
                if (dv[k]) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL dut%0d spurious dig_valid_out", k);
                    end else begin
                        if (!seen) begin
                            chk($sformatf("dut%0d latency", k), 128'(cyc - acc_q[0]), 128'(LAT));
                            seen = 1'b1;
                        end
                        chk($sformatf("dut%0d digest", k), dig[k], exp_q[0]);
                        chk($sformatf("dut%0d ready_while_valid", k), 128'(rdy[k]), 128'd0);
                        if (drdy[k]) begin
                            void'(exp_q.pop_front());
                            void'(acc_q.pop_front());
                            seen = 1'b0;
                        end
                    end
                end
            end
        end
    end

    task automatic start_blk(input int k, input logic [511:0] b, input logic [127:0] c);
        int t = 0;
        blk_data = b;
        chain    = c;
        vin[k]   = 1'b1;
        @(negedge clk);
        while (!rdy[k] && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!rdy[k]) begin
            checks++;
            errors++;
            $display("FAIL dut%0d accept timeout", k);
        end
        @(posedge clk);
        #1;
        vin[k]   = 1'b0;
        blk_data = rand_blk();
        chain    = rand_ch();
        @(negedge clk);
        chk($sformatf("dut%0d busy_after_accept", k), 128'(busy[k]), 128'd1);
    endtask

    task automatic finish_blk(input int k, input int bp, output logic [127:0] res);
        int t = 0;
        res = '0;
        while (!dv[k] && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!dv[k]) begin
            checks++;
            errors++;
            $display("FAIL dut%0d digest timeout", k);
            return;
        end
        repeat (bp) @(negedge clk);
        @(posedge clk);
        #1 drdy[k] = 1'b1;
        @(negedge clk);
        res = dig[k];
        @(posedge clk);
        #1 drdy[k] = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("%s dut%0d ready", tag, k), 128'(rdy[k]), 128'd1);
            chk($sformatf("%s dut%0d valid", tag, k), 128'(dv[k]), 128'd0);
            chk($sformatf("%s dut%0d dig", tag, k), dig[k], 128'd0);
            chk($sformatf("%s dut%0d busy", tag, k), 128'(busy[k]), 128'd0);
        end
    endtask

    // Valid held across the whole exchange; chain for block 2 taken from dig_out.
    task automatic back_to_back(input int k);
        logic [511:0] b1, b2;
        logic [127:0] r1;
        int t = 0;
        b1 = rand_blk();
        b2 = rand_blk();
        r1 = md5_ref(IV, b1);
        blk_data = b1;
        chain    = IV;
        vin[k]   = 1'b1;
        drdy[k]  = 1'b1;
        @(negedge clk);
        while (!rdy[k] && t < 300) begin @(negedge clk); t++; end
        @(posedge clk);
        #1 blk_data = b2;
        t = 0;
        @(negedge clk);
        while (!dv[k] && t < 300) begin @(negedge clk); t++; end
        chk($sformatf("dut%0d b2b first", k), dig[k], r1);
        chain = dig[k];
        @(negedge clk);
        chk($sformatf("dut%0d b2b reaccept", k), 128'(rdy[k]), 128'd1);
        @(posedge clk);
        #1;
        vin[k]   = 1'b0;
        blk_data = rand_blk();
        chain    = rand_ch();
        t = 0;
        @(negedge clk);
        while (!dv[k] && t < 300) begin @(negedge clk); t++; end
        chk($sformatf("dut%0d b2b chained", k), dig[k], md5_ref(r1, b2));
        @(posedge clk);
        #1 drdy[k] = 1'b0;
    endtask

    initial begin
        logic [511:0] b_empty, b_abc;
        logic [127:0] res;
        init_k();
        b_empty = '0;
        b_empty[31:0] = 32'h00000080;
        b_abc = '0;
        b_abc[31:0]    = 32'h80636261;
        b_abc[479:448] = 32'h00000018;

        repeat (3) @(posedge clk);
        #1 check_reset_vals("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int k = 0; k < NI; k++) begin
            start_blk(k, b_empty, IV);
            finish_blk(k, 0, res);
            chk($sformatf("dut%0d empty", k), res, DIG_EMPTY);
            start_blk(k, b_abc, IV);
            finish_blk(k, 1, res);
            chk($sformatf("dut%0d abc", k), res, DIG_ABC);
            for (int n = 0; n < 3; n++) begin
                start_blk(k, rand_blk(), rand_ch());
                finish_blk(k, int'($urandom_range(0, 4)), res);
            end
        end

        start_blk(0, b_abc, IV);
        finish_blk(0, 20, res);
        chk("dut0 backpressure abc", res, DIG_ABC);

        start_blk(1, rand_blk(), IV);
        repeat (29) @(posedge clk);
        chk("dut1 busy_mid_run", 128'(busy[1]), 128'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("midrun");
        @(posedge clk);
        #1 rst_n = 1'b1;
        start_blk(1, b_empty, IV);
        finish_blk(1, 0, res);
        chk("dut1 after_reset empty", res, DIG_EMPTY);

        for (int k = 0; k < NI; k++) back_to_back(k);

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
